sort_ctrl: RTL
==============

# sort_ctrl

Block-sort sequencer around the combinational bitonic network `BN`. Collects a stream of up to 2**LP words over a req/ack handshake, pads short blocks, sorts them in one cycle through `BN`, and streams the sorted block out over a second req/ack handshake. Sits between a word producer and a `seq_merger` input, so presorted runs can be merged downstream.

## Interface
Parameters:
- LP, 3, log2 of block size; PN = 2**LP words per block, LP >= 1
- dw, 8, word width in bits
- dir, 0, sort order; 0 = ascending by output order (smallest first), 1 = descending

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rstn  input  1  reset, asynchronous, active-low
- data_i  input  dw  input word
- req_i  input  1  producer has a valid word
- last_i  input  1  qualifies data_i; the word closes the current block
- ack_i  output  1  controller accepts data_i this cycle
- data_o  output  dw  sorted output word
- req_o  output  1  data_o valid
- last_o  output  1  data_o is the final word of the block
- ack_o  input  1  consumer accepts data_o this cycle
- busy  output  1  state is not FILL, or the fill count is nonzero

## Operation
- Transfers occur on the input side when req_i & ack_i, and on the output side when req_o & ack_o, both in the same cycle. req must not depend on ack.
- States: FILL, SORT, DRAIN.
- FILL:
  - ack_i = 1.
  - Each accepted word is written to buf[cnt], then cnt increments.
  - Go to SORT after the transfer that makes cnt == PN, or after any transfer with last_i = 1.
  - last_i is ignored when req_i = 0.
- SORT (exactly one cycle):
  - ack_i = 0.
  - `BN` input lane k = buf[k] for k < cnt; otherwise PAD, where PAD is all ones for dir=0 and all zeros for dir=1.
  - The `BN` output is registered into sbuf. idx is cleared. Go to DRAIN.
- DRAIN:
  - req_o = 1.
  - data_o = sbuf[idx].
  - last_o = (idx == cnt-1).
  - On each output transfer, idx increments.
  - On the transfer with last_o = 1: cnt is cleared and the state goes to FILL.
- Padding is only ever emitted as part of lanes >= cnt, which are never output.
  - Real words equal to PAD sort identically to pad lanes, so the first cnt lanes remain the correct sorted result.
- The block count cnt is 1..PN. An empty block is impossible, because last_i always travels with a word.
- Counters cnt and idx are LP+1 bits wide. cnt never exceeds PN; idx never exceeds cnt-1.
- No input is accepted during SORT or DRAIN. The producer is stalled by ack_i = 0.

## Timing
- Reset values: state = FILL, cnt = 0, idx = 0; ack_i = 1, req_o = 0, last_o = 0, busy = 0; data_o = 0 (sbuf cleared).
- Reset asserted in any state discards the partial block and sorted data immediately. Outputs take their reset values asynchronously.
- Latency: the first sorted word appears with req_o = 1 two cycles after the closing input transfer (SORT cycle, then DRAIN).
- Full-rate throughput per block: n input cycles + 1 + n output cycles, where n = cnt.
- After the last output transfer, ack_i = 1 in the next cycle. Back-to-back blocks have no extra bubbles.
- data_o and last_o are stable while req_o = 1 and ack_o = 0.
- Simultaneous last_i = 1 on the PN-th word: a single close; the block holds PN words.

## Structure
- Shared package `sorter_pkg`:
  - state enum (FILL, SORT, DRAIN)
  - function pad_val(dir, dw)
- Instantiates the existing `BN #(LP, dw, dir)` as its single sub-module.
- buf and sbuf are packed [PN-1:0][dw-1:0] arrays matching the `BN` port shape.

## Test plan
- LP=3, dir=0; input 5,3,7,1,8,2,6,4 with no last_i; ack_o = 1 -> output 1..8, last_o on 8, first req_o two cycles after the 8th accept.
- Partial block 9,2,5 with last_i on 5 -> output 2,5,9 only; last_o on 9; no pad value emitted.
- Partial block FF,10 (dw=8) -> output 10,FF; exactly two words.
- dir=1, input 1..8 -> output 8..1; partial block 3,7 -> output 7,3 (pad 00 never emitted).
- ack_o toggling 1,0,0,1,... during DRAIN -> data_o and last_o held while stalled; ack_i = 0 throughout DRAIN; sequence still sorted.
- Two blocks back-to-back, then rstn pulsed low mid-DRAIN -> immediate req_o = 0, ack_i = 1, busy = 0. A following 2-word block sorts correctly with no stale data.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared types and helpers for the block-sort sequencer.
// Holds the controller state encoding and the pad-word rule.
package sorter_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int MAXW = 64;

  // Pad must sort behind every real word: all ones ascending, zeros descending.
  function automatic logic [MAXW-1:0] pad_val(
    input logic dir,
    input int   dw
  );
    if (dir)
      return '0;
    return {MAXW{1'b1}} >> (MAXW - dw);
  endfunction

endpackage

// File: rtl/sort_ctrl_bn.sv
// Combinational bitonic sorting network over 2**LP lanes.
// dir=0 puts the smallest word in lane 0; dir=1 the largest.
module BN #(
  parameter int LP  = 3,
  parameter int dw  = 8,
  parameter bit dir = 1'b0
) (
  input  logic [2**LP-1:0][dw-1:0] data_i,
  output logic [2**LP-1:0][dw-1:0] data_o
);

  localparam int PN = 2**LP;

  logic [PN-1:0][dw-1:0] v;
  logic [dw-1:0]         tmp;
  logic                  up;
  int                    l;

  always_comb begin
    v   = data_i;
    tmp = '0;
    up  = 1'b0;
    l   = 0;
    for (int s = 1; s <= LP; s++) begin
      for (int t = s - 1; t >= 0; t--) begin
        for (int i = 0; i < PN; i++) begin
          l = i ^ (1 << t);
          if (l > i) begin
            up = (((i & (1 << s)) == 0) ? 1'b1 : 1'b0) ^ dir;
            if (up ? (v[LP'(i)] > v[LP'(l)])
                   : (v[LP'(i)] < v[LP'(l)])) begin
              tmp       = v[LP'(i)];
              v[LP'(i)] = v[LP'(l)];
              v[LP'(l)] = tmp;
            end
          end
        end
      end
    end
    data_o = v;
  end

endmodule

// File: rtl/sort_ctrl.sv
// Block-sort sequencer: fill up to 2**LP words, sort in one cycle,
// then stream the sorted block out over a req/ack handshake.
module sort_ctrl
  import sorter_pkg::*;
#(
  parameter int LP  = 3,
  parameter int dw  = 8,
  parameter bit dir = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [dw-1:0] data_i,
  input  logic          req_i,
  input  logic          last_i,
  output logic          ack_i,
  output logic [dw-1:0] data_o,
  output logic          req_o,
  output logic          last_o,
  input  logic          ack_o,
  output logic          busy
);

  localparam int PN = 2**LP;
  localparam int CW = LP + 1;
  localparam logic [dw-1:0] PAD = dw'(pad_val(dir, dw));
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TOP = CW'(PN - 1);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         idx_q;
  logic [PN-1:0][dw-1:0] buf_q;
  logic [PN-1:0][dw-1:0] sbuf_q;
  logic [PN-1:0][dw-1:0] bn_in;
  logic [PN-1:0][dw-1:0] bn_out;
  logic                  last_idx;

  // Lanes past the block length carry pad so they settle behind real words.
  for (genvar g = 0; g < PN; g++) begin : g_lane
    assign bn_in[g] = (cnt_q > CW'(g)) ? buf_q[g] : PAD;
  end

  BN #(
    .LP (LP),
    .dw (dw),
    .dir(dir)
  ) u_bn (
    .data_i(bn_in),
    .data_o(bn_out)
  );

  assign last_idx = (idx_q == cnt_q - ONE);
  assign ack_i    = (state_q == FILL);
  assign req_o    = (state_q == DRAIN);
  assign last_o   = req_o & last_idx;
  assign data_o   = sbuf_q[idx_q[LP-1:0]];
  assign busy     = (state_q != FILL) || (cnt_q != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      sbuf_q  <= '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (req_i) begin
            buf_q[cnt_q[LP-1:0]] <= data_i;
            cnt_q                <= cnt_q + ONE;
            if (last_i || cnt_q == TOP)
              state_q <= SORT;
          end
        end
        SORT: begin
          sbuf_q  <= bn_out;
          idx_q   <= '0;
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (ack_o) begin
            if (last_idx) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= FILL;
            end else begin
              idx_q <= idx_q + ONE;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule
